// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator: converts a note gate into a stepped amplitude
// envelope that advances one step per sample-rate tick; gate edges are handled at clk rate.
module adsr_envelope #(
  parameter int unsigned ENV_BITS       = 16,
  parameter int unsigned AMPLITUDE_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      gate,
  input  logic [ENV_BITS-1:0]       attack_rate,
  input  logic [ENV_BITS-1:0]       decay_rate,
  input  logic [AMPLITUDE_BITS-1:0] sustain_level,
  input  logic [ENV_BITS-1:0]       release_rate,
  output logic [AMPLITUDE_BITS-1:0] amplitude,
  output logic                      active,
  output logic [2:0]                state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [ENV_BITS:0] L_MAX = {1'b0, {ENV_BITS{1'b1}}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ENV_BITS-1:0] r_env;
  logic [ENV_BITS-1:0] w_env_nxt;
  logic                r_gate_s;
  logic                r_gate_q;
  logic                w_rise;
  logic                w_fall;
  logic [ENV_BITS-1:0] w_s_tgt;
  logic [ENV_BITS:0]   w_att_sum;
  logic [ENV_BITS:0]   w_dec_dif;

  // The gate pipeline keeps sampling through reset, so a gate held across reset
  // release is seen as a steady level rather than a fresh note-on.
  always_ff @(posedge clk) begin
    r_gate_s <= gate;
    r_gate_q <= r_gate_s;
  end

  assign w_rise    = r_gate_s & ~r_gate_q;
  assign w_fall    = ~r_gate_s & r_gate_q;
  assign w_s_tgt   = {sustain_level, {(ENV_BITS-AMPLITUDE_BITS){1'b0}}};
  assign w_att_sum = {1'b0, r_env} + {1'b0, attack_rate};
  assign w_dec_dif = {1'b0, r_env} - {1'b0, decay_rate};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_env   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (w_rise) begin
      w_state_nxt = ATTACK;
    end else if (w_fall) begin
      if (r_state == ATTACK || r_state == DECAY || r_state == SUSTAIN)
        w_state_nxt = RELEASE;
    end else begin
      case (r_state)
        IDLE: w_env_nxt = '0;
        ATTACK: begin
          if (tick) begin
            if (w_att_sum >= L_MAX) begin
              w_env_nxt   = '1;
              w_state_nxt = DECAY;
            end else begin
              w_env_nxt = w_att_sum[ENV_BITS-1:0];
            end
          end
        end
        DECAY: begin
          if (tick) begin
            // Top bit set means the subtraction wrapped below zero.
            if (w_dec_dif[ENV_BITS] || (w_dec_dif[ENV_BITS-1:0] <= w_s_tgt)) begin
              w_env_nxt   = w_s_tgt;
              w_state_nxt = SUSTAIN;
            end else begin
              w_env_nxt = w_dec_dif[ENV_BITS-1:0];
            end
          end
        end
        SUSTAIN: w_env_nxt = w_s_tgt;
        RELEASE: begin
          if (tick) begin
            if (release_rate >= r_env) begin
              w_env_nxt   = '0;
              w_state_nxt = IDLE;
            end else begin
              w_env_nxt = r_env - release_rate;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_env_nxt   = '0;
        end
      endcase
    end
  end

  assign amplitude = r_env[ENV_BITS-1 -: AMPLITUDE_BITS];
  assign active    = (r_state != IDLE);
  assign state     = r_state;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: reset, ADSR phases, retrigger, hold, short pulse.
module tb_adsr_envelope;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] attack_rate = '0;
  logic [15:0] decay_rate = '0;
  logic [7:0]  sustain_level = '0;
  logic [15:0] release_rate = '0;
  logic [7:0]  amplitude;
  logic        active;
  logic [2:0]  state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  adsr_envelope #(.ENV_BITS(16), .AMPLITUDE_BITS(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .amplitude(amplitude), .active(active), .state(state)
  );

  always #5 clk = ~clk;

  // One clock with the given tick level; returns 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // One envelope step at the bench's sample rate (tick every 4 clk).
  task automatic tick4();
    cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
  endtask

  // Gate edge takes two clocks to reach the state register.
  task automatic set_gate(input logic v);
    gate = v;
    cyc(1'b0);
    cyc(1'b0);
  endtask

  task automatic test_reset();
    gate = 1'b1;
    rst  = 1'b1;
    repeat (3) cyc(1'b0);
    n_checks++;
    if (amplitude !== 8'h00 || active !== 1'b0 || state !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_outputs amp=%h active=%b state=%0d want 00 0 0", amplitude, active, state);
    end
    rst = 1'b0;
    repeat (4) cyc(1'b1);
    n_checks++;
    if (state !== 3'd0 || active !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_gate_held state=%0d active=%b want 0 0", state, active);
    end
  endtask

  task automatic test_attack();
    logic [15:0] exp_env;
    set_gate(1'b0);
    attack_rate   = 16'h1000;
    decay_rate    = 16'h0800;
    sustain_level = 8'h80;
    set_gate(1'b1);
    n_checks++;
    if (state !== 3'd1 || active !== 1'b1 || amplitude !== 8'h00) begin
      n_errors++;
      $display("FAIL attack_enter state=%0d active=%b amp=%h want 1 1 00", state, active, amplitude);
    end
    for (int k = 1; k <= 15; k++) begin
      tick4();
      exp_env = 16'(k * 16'h1000);
      n_checks++;
      if (amplitude !== exp_env[15:8] || state !== 3'd1) begin
        n_errors++;
        $display("FAIL attack_step%0d amp=%h state=%0d want %h 1", k, amplitude, state, exp_env[15:8]);
      end
    end
    tick4();
    n_checks++;
    if (amplitude !== 8'hFF || state !== 3'd2) begin
      n_errors++;
      $display("FAIL attack_peak amp=%h state=%0d want ff 2", amplitude, state);
    end
  endtask

  task automatic test_decay();
    logic [15:0] exp_env;
    for (int k = 1; k <= 15; k++) begin
      tick4();
      exp_env = 16'(32'hFFFF - k * 32'h0800);
      n_checks++;
      if (amplitude !== exp_env[15:8] || state !== 3'd2) begin
        n_errors++;
        $display("FAIL decay_step%0d amp=%h state=%0d want %h 2", k, amplitude, state, exp_env[15:8]);
      end
    end
    tick4();
    n_checks++;
    if (amplitude !== 8'h80 || state !== 3'd3) begin
      n_errors++;
      $display("FAIL decay_clamp amp=%h state=%0d want 80 3", amplitude, state);
    end
    sustain_level = 8'h40;
    cyc(1'b0);
    n_checks++;
    if (amplitude !== 8'h40 || state !== 3'd3) begin
      n_errors++;
      $display("FAIL sustain_track amp=%h state=%0d want 40 3", amplitude, state);
    end
    sustain_level = 8'h80;
    cyc(1'b0);
    n_checks++;
    if (amplitude !== 8'h80) begin
      n_errors++;
      $display("FAIL sustain_restore amp=%h want 80", amplitude);
    end
  endtask

  task automatic test_release();
    logic [15:0] exp_env;
    release_rate = 16'h0400;
    set_gate(1'b0);
    n_checks++;
    if (state !== 3'd4 || amplitude !== 8'h80 || active !== 1'b1) begin
      n_errors++;
      $display("FAIL release_enter state=%0d amp=%h active=%b want 4 80 1", state, amplitude, active);
    end
    for (int k = 1; k <= 31; k++) begin
      tick4();
      exp_env = 16'(32'h8000 - k * 32'h0400);
      n_checks++;
      if (amplitude !== exp_env[15:8] || state !== 3'd4) begin
        n_errors++;
        $display("FAIL release_step%0d amp=%h state=%0d want %h 4", k, amplitude, state, exp_env[15:8]);
      end
    end
    tick4();
    n_checks++;
    if (amplitude !== 8'h00 || state !== 3'd0 || active !== 1'b0) begin
      n_errors++;
      $display("FAIL release_end amp=%h state=%0d active=%b want 00 0 0", amplitude, state, active);
    end
  endtask

  task automatic test_retrigger();
    attack_rate   = 16'hFFFF;
    decay_rate    = 16'hFFFF;
    sustain_level = 8'h80;
    set_gate(1'b1);
    tick4();
    n_checks++;
    if (amplitude !== 8'hFF || state !== 3'd2) begin
      n_errors++;
      $display("FAIL fast_attack amp=%h state=%0d want ff 2", amplitude, state);
    end
    tick4();
    n_checks++;
    if (amplitude !== 8'h80 || state !== 3'd3) begin
      n_errors++;
      $display("FAIL decay_underflow amp=%h state=%0d want 80 3", amplitude, state);
    end
    set_gate(1'b0);
    repeat (20) tick4();
    n_checks++;
    if (amplitude !== 8'h30 || state !== 3'd4) begin
      n_errors++;
      $display("FAIL release_mid amp=%h state=%0d want 30 4", amplitude, state);
    end
    attack_rate = 16'h1000;
    gate = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    n_checks++;
    if (amplitude !== 8'h30 || state !== 3'd1) begin
      n_errors++;
      $display("FAIL retrigger_keep amp=%h state=%0d want 30 1", amplitude, state);
    end
    tick4();
    n_checks++;
    if (amplitude !== 8'h40 || state !== 3'd1) begin
      n_errors++;
      $display("FAIL retrigger_step amp=%h state=%0d want 40 1", amplitude, state);
    end
  endtask

  task automatic test_hold();
    attack_rate = 16'h0000;
    repeat (3) tick4();
    n_checks++;
    if (amplitude !== 8'h40 || state !== 3'd1) begin
      n_errors++;
      $display("FAIL attack_hold amp=%h state=%0d want 40 1", amplitude, state);
    end
    set_gate(1'b0);
    n_checks++;
    if (amplitude !== 8'h40 || state !== 3'd4) begin
      n_errors++;
      $display("FAIL hold_fall amp=%h state=%0d want 40 4", amplitude, state);
    end
  endtask

  task automatic test_reset_decay();
    attack_rate   = 16'hFFFF;
    decay_rate    = 16'h0100;
    sustain_level = 8'h80;
    set_gate(1'b1);
    tick4();
    tick4();
    n_checks++;
    if (amplitude !== 8'hFE || state !== 3'd2) begin
      n_errors++;
      $display("FAIL decay_before_rst amp=%h state=%0d want fe 2", amplitude, state);
    end
    rst = 1'b1;
    cyc(1'b0);
    n_checks++;
    if (amplitude !== 8'h00 || state !== 3'd0 || active !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_in_decay amp=%h state=%0d active=%b want 00 0 0", amplitude, state, active);
    end
    rst = 1'b0;
    repeat (3) cyc(1'b1);
    n_checks++;
    if (state !== 3'd0) begin
      n_errors++;
      $display("FAIL rst_gate_still_high state=%0d want 0", state);
    end
  endtask

  task automatic test_short_pulse();
    attack_rate  = 16'h1000;
    release_rate = 16'h0400;
    set_gate(1'b0);
    gate = 1'b1;
    cyc(1'b0);
    gate = 1'b0;
    cyc(1'b1);
    n_checks++;
    if (state !== 3'd1 || amplitude !== 8'h00) begin
      n_errors++;
      $display("FAIL pulse_attack state=%0d amp=%h want 1 00", state, amplitude);
    end
    cyc(1'b1);
    n_checks++;
    if (state !== 3'd4 || amplitude !== 8'h00) begin
      n_errors++;
      $display("FAIL pulse_release state=%0d amp=%h want 4 00", state, amplitude);
    end
    tick4();
    n_checks++;
    if (state !== 3'd0 || active !== 1'b0) begin
      n_errors++;
      $display("FAIL pulse_idle state=%0d active=%b want 0 0", state, active);
    end
  endtask

  task automatic test_sustain_zero();
    attack_rate   = 16'hFFFF;
    decay_rate    = 16'hFFFF;
    sustain_level = 8'h00;
    set_gate(1'b1);
    tick4();
    tick4();
    repeat (3) tick4();
    n_checks++;
    if (state !== 3'd3 || active !== 1'b1 || amplitude !== 8'h00) begin
      n_errors++;
      $display("FAIL sustain_zero state=%0d active=%b amp=%h want 3 1 00", state, active, amplitude);
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_decay();
    test_release();
    test_retrigger();
    test_hold();
    test_reset_decay();
    test_short_pulse();
    test_sustain_zero();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
